// File: rtl/ddr_pkg.sv
// Shared types, default sizes and helpers for the DDR beat packer.
package ddr_pkg;

    localparam int N_DEF     = 8;
    localparam int BEATS_DEF = 4;
    localparam int BEAT_W    = 2 * N_DEF;
    localparam int CNT_W     = $clog2(BEATS_DEF);

    typedef enum logic {
        IDLE,
        PACK
    } state_t;

    // Mask with the low n bits set; used for the valid-beat keep field.
    function automatic logic [31:0] keep_mask(input int unsigned n);
        return (32'd1 << n) - 32'd1;
    endfunction

endpackage

// File: rtl/ddr_beat_packer_if.sv
// Beat-pair input and packed-word output bus of the DDR beat packer.
// The out_parity wire exists only when DDR_PACKER_PARITY_EN is defined.
interface ddr_beat_packer_if
    import ddr_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int BEATS = BEATS_DEF
);
    logic                   in_valid;
    logic                   in_sof;
    logic                   in_eof;
    logic [N-1:0]           q_rise;
    logic [N-1:0]           q_fall;
    logic                   out_ready;
    logic                   out_valid;
    logic [2*N*BEATS-1:0]   out_data;
    logic                   out_last;
    logic [BEATS-1:0]       out_keep;
`ifdef DDR_PACKER_PARITY_EN
    logic [BEATS-1:0]       out_parity;
`endif

    modport master (
        output in_valid, in_sof, in_eof, q_rise, q_fall, out_ready,
`ifdef DDR_PACKER_PARITY_EN
        input  out_parity,
`endif
        input  out_valid, out_data, out_last, out_keep
    );

    modport slave (
        input  in_valid, in_sof, in_eof, q_rise, q_fall, out_ready,
`ifdef DDR_PACKER_PARITY_EN
        output out_parity,
`endif
        output out_valid, out_data, out_last, out_keep
    );

endinterface

// File: rtl/ddr_out_fifo2.sv
// Two-entry valid/ready queue; a push while full is accepted only if a pop frees a slot.
module ddr_out_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         full,
    output logic         empty
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         wr_en;
    logic         rd_en;

    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (rd_en) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(wr_en) - 2'(rd_en);
        end
    end

    assign head_data = mem[rd_ptr];
    assign full      = (count == 2'd2);
    assign empty     = (count == 2'd0);

endmodule

// File: rtl/ddr_beat_packer.sv
// Packs BEATS {q_rise,q_fall} pairs into one framed word behind a 2-entry output queue.
// Optional per-beat parity output is enabled by defining DDR_PACKER_PARITY_EN.
module ddr_beat_packer
    import ddr_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int BEATS = BEATS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    ddr_beat_packer_if.slave  bus,
    input  logic              clr_ovf,
    output logic              overflow,
    output logic              sof_err
);
    localparam int BW = 2 * N;
    localparam int WW = BW * BEATS;
    localparam int CW = $clog2(BEATS);
`ifdef DDR_PACKER_PARITY_EN
    localparam int PW = WW + 2 * BEATS + 1;
`else
    localparam int PW = WW + BEATS + 1;
`endif

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   wr_idx;
    logic [CW:0]     fill;
    logic [WW-1:0]   acc;
    logic [WW-1:0]   word;
    logic [BW-1:0]   beat;
    logic            accept;
    logic            push;
    logic            push_last;
    logic            sof_err_d;
    logic [BEATS-1:0] push_keep;
    logic [PW-1:0]   push_payload;
    logic [PW-1:0]   head_payload;
    logic            full;
    logic            empty;
    logic            pop;
    logic            drop;

    assign beat = {bus.q_rise, bus.q_fall};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Any eof closes the frame; sof+eof in one beat never leaves IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (bus.in_valid && bus.in_sof && !bus.in_eof) next_state = PACK;
            PACK: if (bus.in_valid && bus.in_eof)                next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A sof always restarts from an all-zero word, so padded beats stay zero.
    always_comb begin
        accept    = bus.in_valid && (state == PACK || bus.in_sof);
        wr_idx    = (state == PACK && !bus.in_sof) ? cnt : '0;
        word      = bus.in_sof ? '0 : acc;
        word[int'(wr_idx)*BW +: BW] = beat;
        fill      = {1'b0, wr_idx} + {{CW{1'b0}}, 1'b1};
        push      = accept && (bus.in_eof || wr_idx == CW'(BEATS - 1));
        push_keep = BEATS'(keep_mask(32'(fill)));
        push_last = bus.in_eof;
        sof_err_d = bus.in_valid && bus.in_sof && state == PACK;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc      <= '0;
            sof_err  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                cnt <= push ? '0 : wr_idx + 1'b1;
                acc <= push ? '0 : word;
            end
            sof_err <= sof_err_d;
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef DDR_PACKER_PARITY_EN
    logic [BEATS-1:0] push_par;

    always_comb begin
        push_par = '0;
        for (int k = 0; k < BEATS; k++) begin
            push_par[k] = ^word[k*BW +: BW];
        end
    end

    assign push_payload   = {push_par, push_last, push_keep, word};
    assign bus.out_parity = head_payload[WW+BEATS+1 +: BEATS];
`else
    assign push_payload   = {push_last, push_keep, word};
`endif

    assign pop  = bus.out_valid && bus.out_ready;
    assign drop = push && full && !pop;

    ddr_out_fifo2 #(.W(PW)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_payload),
        .pop       (pop),
        .head_data (head_payload),
        .full      (full),
        .empty     (empty)
    );

    assign bus.out_valid = !empty;
    assign bus.out_data  = head_payload[WW-1:0];
    assign bus.out_keep  = head_payload[WW +: BEATS];
    assign bus.out_last  = head_payload[WW+BEATS];

endmodule
